// File: rtl/ghost_collision_scanner_if.sv
// Handshake and position bus between the movement logic, the collision scanner
// and the game-state controller.
interface ghost_collision_scanner_if #(
    parameter int unsigned NUM_GHOSTS = 4,
    parameter int unsigned XW         = 10,
    parameter int unsigned YW         = 9
);
    logic                       start;
    logic                       clear;
    logic [XW-1:0]              pac_x;
    logic [YW-1:0]              pac_y;
    logic [NUM_GHOSTS*XW-1:0]   ghost_x;
    logic [NUM_GHOSTS*YW-1:0]   ghost_y;
    logic [NUM_GHOSTS-1:0]      frightened;
    logic                       busy;
    logic                       done;
    logic [NUM_GHOSTS-1:0]      hit_vec;
    logic [NUM_GHOSTS-1:0]      eaten_vec;
    logic                       game_over;

    // Requester side: drives positions and scan requests, observes results.
    modport master (
        output start, clear, pac_x, pac_y, ghost_x, ghost_y, frightened,
        input  busy, done, hit_vec, eaten_vec, game_over
    );

    // Scanner side.
    modport slave (
        input  start, clear, pac_x, pac_y, ghost_x, ghost_y, frightened,
        output busy, done, hit_vec, eaten_vec, game_over
    );
endinterface

// File: rtl/ghost_collision_scanner.sv
// Sequential pac-man/ghost collision scanner: snapshots all positions on start,
// evaluates one ghost per cycle through a shared squared-distance datapath, and
// reports hits, frightened-ghost eats and a sticky game-over flag.
module ghost_collision_scanner #(
    parameter int unsigned NUM_GHOSTS = 4,
    parameter int unsigned XW         = 10,
    parameter int unsigned YW         = 9,
    parameter int unsigned RADIUS_SQ  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    ghost_collision_scanner_if.slave bus
);
    localparam int unsigned IW   = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam int unsigned SXW  = 2 * XW;
    localparam int unsigned SYW  = 2 * YW;
    localparam int unsigned SW   = ((SXW > SYW) ? SXW : SYW) + 1;
    localparam int unsigned CW   = (SW > 32) ? SW : 32;
    localparam logic [IW-1:0] LAST = IW'(NUM_GHOSTS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t                   state;
    logic [IW-1:0]            idx;
    logic [XW-1:0]            px_q;
    logic [YW-1:0]            py_q;
    logic [NUM_GHOSTS*XW-1:0] gx_q;
    logic [NUM_GHOSTS*YW-1:0] gy_q;
    logic [NUM_GHOSTS-1:0]    fr_q;
    logic [NUM_GHOSTS-1:0]    acc_q;

    logic                     busy_q;
    logic                     done_q;
    logic [NUM_GHOSTS-1:0]    hit_q;
    logic [NUM_GHOSTS-1:0]    eaten_q;
    logic                     go_q;

    logic [XW-1:0]            gx_c;
    logic [YW-1:0]            gy_c;
    logic signed [XW:0]       dx_c;
    logic signed [YW:0]       dy_c;
    logic [XW-1:0]            adx_c;
    logic [YW-1:0]            ady_c;
    logic [SXW-1:0]           sqx_c;
    logic [SYW-1:0]           sqy_c;
    logic [SW-1:0]            d2_c;
    logic                     hit_c;
    logic [NUM_GHOSTS-1:0]    acc_fin_c;

    // Shared distance datapath for the ghost selected by idx; widened so nothing wraps.
    always_comb begin
        gx_c      = gx_q[idx*XW +: XW];
        gy_c      = gy_q[idx*YW +: YW];
        dx_c      = $signed({1'b0, px_q}) - $signed({1'b0, gx_c});
        dy_c      = $signed({1'b0, py_q}) - $signed({1'b0, gy_c});
        adx_c     = dx_c[XW] ? XW'(-dx_c) : XW'(dx_c);
        ady_c     = dy_c[YW] ? YW'(-dy_c) : YW'(dy_c);
        sqx_c     = SXW'(adx_c) * SXW'(adx_c);
        sqy_c     = SYW'(ady_c) * SYW'(ady_c);
        d2_c      = SW'(sqx_c) + SW'(sqy_c);
        hit_c     = CW'(d2_c) < CW'(RADIUS_SQ);
        acc_fin_c = acc_q;
        acc_fin_c[idx] = hit_c;
    end

    // Scan sequencer with registered result outputs and sticky game-over.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= '0;
            px_q    <= '0;
            py_q    <= '0;
            gx_q    <= '0;
            gy_q    <= '0;
            fr_q    <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hit_q   <= '0;
            eaten_q <= '0;
            go_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            eaten_q <= '0;

            // A reported hit on a non-frightened ghost beats a simultaneous clear.
            if (state == REPORT && (hit_q & ~fr_q) != '0) begin
                go_q <= 1'b1;
            end else if (bus.clear) begin
                go_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        px_q   <= bus.pac_x;
                        py_q   <= bus.pac_y;
                        gx_q   <= bus.ghost_x;
                        gy_q   <= bus.ghost_y;
                        fr_q   <= bus.frightened;
                        acc_q  <= '0;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    acc_q <= acc_fin_c;
                    if (idx == LAST) begin
                        hit_q   <= acc_fin_c;
                        eaten_q <= acc_fin_c & fr_q;
                        done_q  <= 1'b1;
                        state   <= REPORT;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                REPORT: begin
                    idx    <= '0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.hit_vec   = hit_q;
    assign bus.eaten_vec = eaten_q;
    assign bus.game_over = go_q;
endmodule

// File: tb/tb_ghost_collision_scanner.sv
// Bench for ghost_collision_scanner: transaction-level reference model with a
// per-cycle compare, directed scenarios with literal expectations, then random traffic.
module tb_ghost_collision_scanner;
    localparam int unsigned N  = 4;
    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;
    localparam int unsigned R2 = 1024;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    ghost_collision_scanner_if #(.NUM_GHOSTS(N), .XW(XW), .YW(YW)) bus();

    ghost_collision_scanner #(.NUM_GHOSTS(N), .XW(XW), .YW(YW), .RADIUS_SQ(R2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Euclidean hit test straight from the geometric rule, in plain integers.
    function automatic logic [N-1:0] calc(input logic [XW-1:0] px, input logic [YW-1:0] py,
                                          input logic [N*XW-1:0] gxv, input logic [N*YW-1:0] gyv);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            int dx;
            int dy;
            dx = int'(px) - int'(gxv[i*XW +: XW]);
            dy = int'(py) - int'(gyv[i*YW +: YW]);
            r[i] = (dx*dx + dy*dy) < int'(R2);
        end
        return r;
    endfunction

    // Reference model: m_t counts cycles since an accepted start (0 = idle).
    int           m_t = 0;
    logic [N-1:0] m_hit = '0;
    logic [N-1:0] m_fr = '0;
    logic [N-1:0] p_hit = '0;
    logic [N-1:0] p_fr = '0;
    logic         m_go = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_t   = 0;
            m_hit = '0;
            m_fr  = '0;
            m_go  = 1'b0;
        end else begin
            if (m_t == N + 1 && (m_hit & ~m_fr) != '0) m_go = 1'b1;
            else if (bus.clear) m_go = 1'b0;

            if (m_t == 0) begin
                if (bus.start) begin
                    p_hit = calc(bus.pac_x, bus.pac_y, bus.ghost_x, bus.ghost_y);
                    p_fr  = bus.frightened;
                    m_t   = 1;
                end
            end else if (m_t == N + 1) begin
                m_t = 0;
            end else begin
                m_t++;
                if (m_t == N + 1) begin
                    m_hit = p_hit;
                    m_fr  = p_fr;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic         e_done;
        logic [N-1:0] e_eaten;
        e_done  = (m_t == N + 1);
        e_eaten = e_done ? (m_hit & m_fr) : '0;
        check("busy",      32'(bus.busy),      32'(m_t != 0));
        check("done",      32'(bus.done),      32'(e_done));
        check("hit_vec",   32'(bus.hit_vec),   32'(m_hit));
        check("eaten_vec", 32'(bus.eaten_vec), 32'(e_eaten));
        check("game_over", 32'(bus.game_over), 32'(m_go));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic place(input int g, input int x, input int y);
        bus.ghost_x[g*XW +: XW] = XW'(x);
        bus.ghost_y[g*YW +: YW] = YW'(y);
    endtask

    task automatic all_far();
        for (int i = 0; i < N; i++) place(i, 600, 400);
    endtask

    task automatic set_pac(input int x, input int y);
        bus.pac_x = XW'(x);
        bus.pac_y = YW'(y);
    endtask

    // Pulses start and advances to the REPORT cycle.
    task automatic scan_to_report();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (N) tick();
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    initial begin
        int dcnt;
        int dcyc;
        bus.start      = 1'b0;
        bus.clear      = 1'b0;
        bus.pac_x      = '0;
        bus.pac_y      = '0;
        bus.ghost_x    = '0;
        bus.ghost_y    = '0;
        bus.frightened = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_hit",  32'(bus.hit_vec), 32'd0);
        check("rst_go",   32'(bus.game_over), 32'd0);
        rst = 1'b1;
        tick();

        // Radius boundary: d^2 = 961 hits, d^2 = 1024 does not.
        set_pac(100, 100);
        all_far();
        place(0, 131, 100);
        scan_to_report();
        check("bnd_done",  32'(bus.done), 32'd1);
        check("bnd_hit",   32'(bus.hit_vec), 32'h1);
        check("bnd_model", 32'(m_hit), 32'h1);
        tick();
        check("bnd_go", 32'(bus.game_over), 32'd1);
        pulse_clear();
        check("clr_go", 32'(bus.game_over), 32'd0);
        place(0, 132, 100);
        scan_to_report();
        check("bnd2_hit", 32'(bus.hit_vec), 32'h0);
        tick();
        check("bnd2_go", 32'(bus.game_over), 32'd0);

        // No wrap on differences: (1023,511) is far from (0,0).
        set_pac(0, 0);
        all_far();
        place(2, 1023, 511);
        place(3, 5, 5);
        scan_to_report();
        check("wrap_hit",   32'(bus.hit_vec), 32'h8);
        check("wrap_model", 32'(m_hit), 32'h8);
        tick();
        pulse_clear();

        // Frightened split.
        set_pac(200, 200);
        all_far();
        place(1, 200, 200);
        place(2, 200, 200);
        bus.frightened = 4'b0010;
        scan_to_report();
        check("fr_hit",   32'(bus.hit_vec), 32'h6);
        check("fr_eaten", 32'(bus.eaten_vec), 32'h2);
        tick();
        check("fr_eaten_off", 32'(bus.eaten_vec), 32'h0);
        check("fr_go",        32'(bus.game_over), 32'd1);
        pulse_clear();
        bus.frightened = 4'b0110;
        scan_to_report();
        check("fr2_eaten", 32'(bus.eaten_vec), 32'h6);
        tick();
        check("fr2_go", 32'(bus.game_over), 32'd0);

        // Snapshot and start-while-busy.
        set_pac(300, 300);
        all_far();
        bus.frightened = '0;
        dcnt = 0;
        dcyc = -1;
        bus.start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) begin
                bus.start = 1'b0;
                place(0, 300, 300);
            end
            if (c == 2) bus.start = 1'b1;
            if (c == 3) bus.start = 1'b0;
            if (bus.done) begin
                dcnt++;
                dcyc = c;
            end
        end
        check("snap_done_cnt", 32'(dcnt), 32'd1);
        check("snap_done_cyc", 32'(dcyc), 32'd5);
        check("snap_hit",      32'(bus.hit_vec), 32'h0);

        // Clear versus simultaneous set: set wins; clear alone then drops it.
        scan_to_report();
        tick();
        check("prio_go1", 32'(bus.game_over), 32'd1);
        scan_to_report();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("prio_go2", 32'(bus.game_over), 32'd1);
        pulse_clear();
        check("prio_go3", 32'(bus.game_over), 32'd0);

        // Reset mid-scan aborts with no done, then a fresh scan completes.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_done", 32'(bus.done), 32'd0);
        check("mrst_hit",  32'(bus.hit_vec), 32'h0);
        check("mrst_go",   32'(bus.game_over), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        scan_to_report();
        check("post_done", 32'(bus.done), 32'd1);
        check("post_hit",  32'(bus.hit_vec), 32'h1);
        tick();
        check("post_go", 32'(bus.game_over), 32'd1);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.clear = ($urandom_range(0, 15) == 0);
            set_pac(int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
            for (int g = 0; g < N; g++) begin
                if ($urandom_range(0, 1) == 1)
                    place(g, int'(bus.pac_x) + int'($urandom_range(0, 80)) - 40,
                             int'(bus.pac_y) + int'($urandom_range(0, 80)) - 40);
                else
                    place(g, int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
            end
            bus.frightened = N'($urandom);
            rst = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        rst = 1'b1;
        bus.start = 1'b0;
        bus.clear = 1'b0;
        repeat (8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ghost_collision_scanner.md
# ghost_collision_scanner

Parametrised, sequential successor to the pac-man/ghost crash check. On each per-frame `start` pulse it snapshots the pac-man and all ghost positions, then evaluates one ghost per clock with a time-shared signed squared-distance datapath. It reports a per-ghost hit vector and a one-cycle `done` pulse. Hits are split by mode: a hit on a non-frightened ghost sets the sticky game-over flag, and a hit on a frightened ghost raises an "eaten" pulse. It sits between the character movement logic and the game-state controller.

## Interface
- `NUM_GHOSTS`, default 4: number of ghosts scanned; must be ≥1.
- `XW`, default 10: X coordinate width.
- `YW`, default 9: Y coordinate width.
- `RADIUS_SQ`, default 1024: collision threshold. A hit is declared when dx²+dy² < RADIUS_SQ.

- `clk`  in  1: system clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `start`  in  1: begin a scan; sampled only in IDLE.
- `clear`  in  1: clears `game_over`.
- `pac_x`  in  XW: pac-man X.
- `pac_y`  in  YW: pac-man Y.
- `ghost_x`  in  NUM_GHOSTS*XW: ghost i X at bits [i*XW +: XW].
- `ghost_y`  in  NUM_GHOSTS*YW: ghost i Y at bits [i*YW +: YW].
- `frightened`  in  NUM_GHOSTS: bit i set means ghost i is edible.
- `busy`  out  1: high while a scan is in progress.
- `done`  out  1: one-cycle pulse; results are valid in that cycle.
- `hit_vec`  out  NUM_GHOSTS: ghosts within the radius in the last scan; held until the next `done`.
- `eaten_vec`  out  NUM_GHOSTS: hit AND frightened; asserted only in the `done` cycle, 0 otherwise.
- `game_over`  out  1: sticky; set by any hit on a non-frightened ghost.

## Operation
- FSM states: IDLE, SCAN, REPORT.
  - IDLE → SCAN on `start`=1. In that cycle, snapshot `pac_x`, `pac_y`, `ghost_x`, `ghost_y`, `frightened` and clear the accumulating hit register. Index counter goes to 0.
  - SCAN evaluates ghost[idx] each cycle and writes the result into bit idx of the accumulator. When idx = NUM_GHOSTS-1 the state moves to REPORT; otherwise idx increments.
  - REPORT lasts one cycle, then returns to IDLE.
- Outputs in REPORT:
  - `done`=1.
  - `hit_vec` ← accumulator.
  - `eaten_vec` = accumulator & frightened snapshot.
  - If (accumulator & ~frightened snapshot) ≠ 0, `game_over` is set.
- Arithmetic:
  - dx = zero-extended pac_x − zero-extended ghost_x, computed as XW+1 bits signed. dy likewise at YW+1 bits.
  - Take absolute values, then square: 2*XW bits and 2*YW bits.
  - Sum at max(2*XW, 2*YW)+1 bits, so no overflow or wrap is possible.
  - Compare unsigned and strictly less-than against RADIUS_SQ.
  - Differences must never wrap: pac_x=0, ghost_x=1023 is a distance of 1023, not 1.
- `busy` = (state ≠ IDLE).
- `start` is ignored while busy; there is no queuing.
- Input changes after the snapshot cycle do not affect the scan in progress.
- `clear`: clears `game_over` when it is 1. If clear and a game-over set occur in the same cycle, the set wins.
- Reset mid-scan aborts immediately. State goes to IDLE and all outputs go to reset values. No `done` is produced for the aborted scan.

## Timing
- Reset values: `busy`=0, `done`=0, `hit_vec`=0, `eaten_vec`=0, `game_over`=0; FSM=IDLE; idx=0.
- Cycle 0: `start` is sampled high.
- Cycles 1..NUM_GHOSTS: SCAN. `busy`=1 from cycle 1.
- Cycle NUM_GHOSTS+1: REPORT, with `done`=1, new `hit_vec`, and `eaten_vec` valid.
- `game_over` is visible at cycle NUM_GHOSTS+2.
- Default parameters: `done` arrives 5 cycles after `start`.
- Minimum start-to-start spacing is NUM_GHOSTS+2 cycles. A `start` held high re-triggers in the cycle after REPORT.
- The datapath is combinational within the SCAN cycle: one squarer pair and one comparator are shared across all ghosts.

## Test plan
- Boundary radius: pac (100,100), ghost0 (131,100), others far (600,400), none frightened → `hit_vec`=0001, `game_over`=1 after `done`. Repeat with ghost0 at (132,100) (d²=1024) → `hit_vec`=0000, `game_over` stays 0 (after `clear`).
- Wrap-around: pac (0,0), ghost2 (1023,511), ghost3 (5,5) → only bit 3 set. Ghost2 must not alias to distance 1.
- Frightened split: ghosts 1 and 2 both at pac position, `frightened`=0010 → `hit_vec`=0110, `eaten_vec`=0010 for exactly one cycle, `game_over`=1. With `frightened`=0110 → `game_over` stays 0.
- Snapshot/busy: move ghost0 onto pac in the cycle after `start` and pulse `start` again mid-scan → `hit_vec`=0000, exactly one `done` at cycle 5.
- Clear priority: `game_over`=1, then assert `clear` in the same cycle a new non-frightened hit reports → `game_over` remains 1. `clear` alone → 0 next cycle.
- Reset mid-scan: drop `rst` at cycle 2 of a scan that would hit → all outputs 0 immediately, no `done`. A new `start` after release completes normally.
